uart_receiver_control: RTL
==========================

UART_RECEIVER_CONTROL -- requirements
Module: uart_receiver_control

Interface
REQ-001 SHALL have parameter OSR, default 16, meaning baud_tick pulses per serial bit.
REQ-002 SHALL have port pclk, input, 1, the only clock; all logic is rising-edge.
REQ-003 SHALL have port preset, input, 1, asynchronous, active-high reset.
REQ-004 SHALL have port rx_en, input, 1, receiver enable; 0 holds the FSM in IDLE.
REQ-005 SHALL have port baud_tick, input, 1, one-pclk pulse at OSR x baud rate.
REQ-006 SHALL have port rx_data, input, 1, majority-voted serial bit from the shift block.
REQ-007 SHALL have ports wls, input, 2, word length select (5 + wls data bits), and pen, input, 1, parity enable.
REQ-008 SHALL have port eps, input, 1, even parity select (1 = even, 0 = odd).
REQ-009 SHALL have port all_zero, input, 1, receive shift register is all zero.
REQ-010 SHALL have ports voting_shift_en, output, 1, and receive_shift_en, output, 1, shift strobes to the shift block.
REQ-011 SHALL have port error_check, output, 1, qualifies the shift block's frame_error.
REQ-012 SHALL have ports rx_done, output, 1, one-cycle frame-complete pulse; parity_error, output, 1; break_det, output, 1; busy, output, 1.

Function
REQ-013 SHALL implement states IDLE, START, DATA, CHECK with a 4-bit tick counter tcnt (0..OSR-1) and a 4-bit bit counter bcnt.
REQ-014 In IDLE: voting_shift_en = baud_tick & rx_en; on baud_tick with rx_en=1 and rx_data=0 -> START, tcnt=0.
REQ-015 In START and DATA: tcnt increments on every baud_tick and wraps OSR-1 -> 0; voting_shift_en = baud_tick & (tcnt in {7,8,9}).
REQ-016 receive_shift_en SHALL equal baud_tick & (tcnt==10) in START and DATA; never asserted in IDLE or CHECK.
REQ-017 In START at the tcnt==10 tick: rx_data=1 -> false start, return to IDLE, no shift; rx_data=0 -> assert receive_shift_en, bcnt=1, -> DATA.
REQ-018 Frame shift count N = 7 + wls + pen (start + data + optional parity + one stop); range 7..11.
REQ-019 In DATA each tcnt==10 tick SHALL shift and increment bcnt; the shift at which bcnt becomes N -> CHECK on the next edge.
REQ-020 Parity accumulator SHALL XOR rx_data at shifts with bcnt 1..N-2 (data plus parity bit, stop excluded); cleared on START entry.
REQ-021 CHECK SHALL last exactly one pclk: error_check=1, rx_done=1, parity_error = pen & (acc ^ ~eps), break_det = all_zero; then -> IDLE.
REQ-022 parity_error and break_det SHALL be registered, valid only while rx_done=1, otherwise 0.
REQ-023 busy SHALL be 1 in START, DATA, CHECK; 0 in IDLE.
REQ-024 rx_en deasserted in START or DATA SHALL abort to IDLE at the next edge with no rx_done; wls/pen/eps changes mid-frame are unsupported (sampled each cycle, no latch).
REQ-025 baud_tick coincident with CHECK SHALL be ignored for counting.

Reset
REQ-026 preset=1 SHALL asynchronously force IDLE, tcnt=0, bcnt=0, acc=0, all outputs 0.
REQ-027 Reset mid-frame SHALL discard the frame; no rx_done after release.

Structure
REQ-028 State encoding and constants (OSR default, vote ticks 7/8/9, shift tick 10) SHALL live in shared package uart_pkg.
REQ-029 A sub-module uart_tick_counter (tcnt with wrap and decode) is natural; FSM stays in this module; target 120-250 RTL lines.

Verification
REQ-030 wls=11, pen=0, byte 0x55: exactly 10 receive_shift_en pulses, rx_done 1 pclk after the 10th, parity_error=0, break_det=0.
REQ-031 wls=00, pen=1, eps=1, data 0x13 with wrong parity bit 0: 8 shifts, rx_done with parity_error=1.
REQ-032 Start glitch low for 3 ticks then high: START entered, at tcnt==10 rx_data=1 -> IDLE, no receive_shift_en, no rx_done.
REQ-033 Line held low 12 bit-times, wls=11, pen=1: rx_done with break_det=1, error_check=1.
REQ-034 preset pulsed during DATA bcnt=4: outputs 0 immediately, busy=0, next clean frame received correctly.
REQ-035 rx_en dropped at bcnt=3: IDLE next edge, no rx_done; voting_shift_en stops.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared FSM encoding and tick constants for the UART receive control.
// Rev    : 1.0
// ============================================================================
package uart_pkg;

  localparam int OSR_DEFAULT = 16;

  // Votes are taken on the three ticks before the bit is committed at tick 10.
  localparam logic [3:0] VOTE_TICK_FIRST = 4'd7;
  localparam logic [3:0] VOTE_TICK_LAST  = 4'd9;
  localparam logic [3:0] SHIFT_TICK      = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_CHECK = 2'd3
  } rx_state_e;

  // Start + (5 + wls) data + optional parity + one stop bit.
  function automatic logic [3:0] frame_shifts(input logic [1:0] wls, input logic pen);
    return 4'd7 + {2'b00, wls} + {3'b000, pen};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tick_counter.sv
`default_nettype none
// ============================================================================
// Module : uart_tick_counter
// Brief  : Oversampling tick counter with vote-window and shift-point decode.
// Rev    : 1.0
// ============================================================================
module uart_tick_counter
  import uart_pkg::*;
#(
  parameter int OSR = OSR_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic vote_tick,
  output logic shift_tick
);

  logic [3:0] tcnt_q;
  logic [3:0] tcnt_d;

  always_comb begin
    tcnt_d = tcnt_q;
    if (clear) begin
      tcnt_d = 4'd0;
    end else if (tick) begin
      tcnt_d = (tcnt_q == 4'(OSR - 1)) ? 4'd0 : tcnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q <= 4'd0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end

  assign vote_tick  = tick & (tcnt_q >= VOTE_TICK_FIRST) & (tcnt_q <= VOTE_TICK_LAST);
  assign shift_tick = tick & (tcnt_q == SHIFT_TICK);

endmodule
`default_nettype wire

// File: rtl/uart_receiver_control.sv
`default_nettype none
// ============================================================================
// Module : uart_receiver_control
// Brief  : UART receive sequencing FSM: start qualify, bit shifting, parity/break check.
// Rev    : 1.0
// ============================================================================
module uart_receiver_control
  import uart_pkg::*;
#(
  parameter int OSR = OSR_DEFAULT
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       rx_en,
  input  logic       baud_tick,
  input  logic       rx_data,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       eps,
  input  logic       all_zero,
  output logic       voting_shift_en,
  output logic       receive_shift_en,
  output logic       error_check,
  output logic       rx_done,
  output logic       parity_error,
  output logic       break_det,
  output logic       busy
);

  rx_state_e  state_q, state_d;
  logic [3:0] bcnt_q, bcnt_d;
  logic       acc_q, acc_d;
  logic       parity_error_q, parity_error_d;
  logic       break_det_q, break_det_d;
  logic       active;
  logic       vote_tick;
  logic       shift_tick;
  logic [3:0] n_shifts;

  assign active   = (state_q == ST_START) || (state_q == ST_DATA);
  assign n_shifts = frame_shifts(wls, pen);

  // Counter is held at zero outside START/DATA so a new frame always starts at 0.
  uart_tick_counter #(
    .OSR(OSR)
  ) u_tick_counter (
    .clk       (pclk),
    .rst       (preset),
    .clear     (~active),
    .tick      (baud_tick & active),
    .vote_tick (vote_tick),
    .shift_tick(shift_tick)
  );

  always_comb begin
    state_d          = state_q;
    bcnt_d           = bcnt_q;
    acc_d            = acc_q;
    parity_error_d   = 1'b0;
    break_det_d      = 1'b0;
    voting_shift_en  = 1'b0;
    receive_shift_en = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bcnt_d          = 4'd0;
        voting_shift_en = baud_tick & rx_en & ~preset;
        if (baud_tick && rx_en && !rx_data) begin
          state_d = ST_START;
          acc_d   = 1'b0;
        end
      end

      ST_START: begin
        voting_shift_en = vote_tick;
        if (!rx_en) begin
          state_d = ST_IDLE;
        end else if (shift_tick) begin
          if (rx_data) begin
            state_d = ST_IDLE;
          end else begin
            receive_shift_en = 1'b1;
            bcnt_d           = 4'd1;
            state_d          = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        voting_shift_en  = vote_tick;
        receive_shift_en = shift_tick;
        if (!rx_en) begin
          state_d = ST_IDLE;
        end else if (shift_tick) begin
          bcnt_d = bcnt_q + 4'd1;
          // Data and parity bits feed the accumulator; the stop bit does not.
          if (bcnt_q <= n_shifts - 4'd2) begin
            acc_d = acc_q ^ rx_data;
          end
          if (bcnt_d >= n_shifts) begin
            state_d        = ST_CHECK;
            parity_error_d = pen & (acc_d ^ ~eps);
            break_det_d    = all_zero;
          end
        end
      end

      ST_CHECK: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q        <= ST_IDLE;
      bcnt_q         <= 4'd0;
      acc_q          <= 1'b0;
      parity_error_q <= 1'b0;
      break_det_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      bcnt_q         <= bcnt_d;
      acc_q          <= acc_d;
      parity_error_q <= parity_error_d;
      break_det_q    <= break_det_d;
    end
  end

  assign rx_done      = (state_q == ST_CHECK);
  assign error_check  = (state_q == ST_CHECK);
  assign busy         = (state_q != ST_IDLE);
  assign parity_error = parity_error_q;
  assign break_det    = break_det_q;

endmodule
`default_nettype wire
